// File: rtl/spi_slave_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_slave_ctrl_if : SPI-slave controller strobe/handshake bundle          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface spi_slave_ctrl_if;
  logic sck_rise;
  logic cs;
  logic mosi;
  logic miso_en;
  logic addr_we;
  logic sr_we;
  logic dm_we;
  logic addr_inc;
  logic busy;

  modport master (
    output sck_rise, cs, mosi,
    input  miso_en, addr_we, sr_we, dm_we, addr_inc, busy
  );

  modport slave (
    input  sck_rise, cs, mosi,
    output miso_en, addr_we, sr_we, dm_we, addr_inc, busy
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_slave_ctrl : SPI-slave address / R-W / data phase sequencer           |
// | Option SPI_SLAVE_BURST_EN: multi-word bursts with address increment.     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module spi_slave_ctrl #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter bit READ_BIT = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  spi_slave_ctrl_if.slave  spi
);
  localparam int c_MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int c_CNT_W = $clog2(c_MAX_W + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(ADDR_W - 1);
  localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ADDR  = 3'd1;
  localparam logic [2:0] c_RW    = 3'd2;
  localparam logic [2:0] c_READ  = 3'd3;
  localparam logic [2:0] c_WRITE = 3'd4;
  localparam logic [2:0] c_DONE  = 3'd5;

  logic [2:0]         r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic r_miso_en, r_addr_we, r_sr_we, r_dm_we, r_busy;
  logic w_miso_en_nxt, w_addr_we_nxt, w_sr_we_nxt, w_dm_we_nxt, w_busy_nxt;
  logic w_abort, w_addr_last, w_data_last, w_is_read;
`ifdef SPI_SLAVE_BURST_EN
  logic r_addr_inc, r_sr_pend;
  logic w_addr_inc_nxt, w_sr_pend_nxt;
`endif

  assign w_abort     = (r_state != c_IDLE) && spi.cs;
  assign w_addr_last = spi.sck_rise && (r_cnt == c_ADDR_LAST);
  assign w_data_last = spi.sck_rise && (r_cnt == c_DATA_LAST);
  assign w_is_read   = (spi.mosi == READ_BIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_miso_en <= 1'b0;
      r_addr_we <= 1'b0;
      r_sr_we   <= 1'b0;
      r_dm_we   <= 1'b0;
      r_busy    <= 1'b0;
`ifdef SPI_SLAVE_BURST_EN
      r_addr_inc <= 1'b0;
      r_sr_pend  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_miso_en <= w_miso_en_nxt;
      r_addr_we <= w_addr_we_nxt;
      r_sr_we   <= w_sr_we_nxt;
      r_dm_we   <= w_dm_we_nxt;
      r_busy    <= w_busy_nxt;
`ifdef SPI_SLAVE_BURST_EN
      r_addr_inc <= w_addr_inc_nxt;
      r_sr_pend  <= w_sr_pend_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_abort) begin
      w_state_nxt = c_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (!spi.cs) begin
            w_state_nxt = c_ADDR;
            w_cnt_nxt   = '0;
          end
        end
        c_ADDR: begin
          if (w_addr_last) begin
            w_state_nxt = c_RW;
            w_cnt_nxt   = '0;
          end else if (spi.sck_rise) begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end
        c_RW: begin
          if (spi.sck_rise) begin
            w_state_nxt = w_is_read ? c_READ : c_WRITE;
            w_cnt_nxt   = '0;
          end
        end
        c_READ, c_WRITE: begin
          if (w_data_last) begin
            w_cnt_nxt = '0;
`ifndef SPI_SLAVE_BURST_EN
            w_state_nxt = c_DONE;
`endif
          end else if (spi.sck_rise) begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end
        c_DONE: ;
        default: begin
          w_state_nxt = c_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Strobes are all gated by abort so that a cs rise discards a partial word.
  always_comb begin
    w_busy_nxt    = (w_state_nxt != c_IDLE);
    w_miso_en_nxt = (w_state_nxt == c_READ) ||
                    ((w_state_nxt == c_DONE) && ((r_state == c_READ) || r_miso_en));
    w_addr_we_nxt = !w_abort && (r_state == c_ADDR) && w_addr_last;
    w_dm_we_nxt   = !w_abort && (r_state == c_WRITE) && w_data_last;
    w_sr_we_nxt   = !w_abort && (r_state == c_RW) && spi.sck_rise && w_is_read;
`ifdef SPI_SLAVE_BURST_EN
    w_addr_inc_nxt = !w_abort && ((r_state == c_READ) || (r_state == c_WRITE)) && w_data_last;
    w_sr_pend_nxt  = !w_abort && (r_state == c_READ) && w_data_last;
    w_sr_we_nxt    = w_sr_we_nxt || (!w_abort && r_sr_pend);
`endif
  end

  assign spi.miso_en = r_miso_en;
  assign spi.addr_we = r_addr_we;
  assign spi.sr_we   = r_sr_we;
  assign spi.dm_we   = r_dm_we;
  assign spi.busy    = r_busy;
`ifdef SPI_SLAVE_BURST_EN
  assign spi.addr_inc = r_addr_inc;
`else
  assign spi.addr_inc = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_slave_ctrl : self-checking bench for spi_slave_ctrl               |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_spi_slave_ctrl;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int RW_EDGE = ADDR_W + 1;
`ifdef SPI_SLAVE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_slave_ctrl_if bus ();

  spi_slave_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .READ_BIT (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .spi   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Transaction-level model: edges seen since cs fell, and the decoded R/W bit.
  bit m_active = 1'b0;
  int m_edges  = 0;
  bit m_rd     = 1'b0;
  bit m_pend   = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input bit ea, input bit es, input bit ed,
                           input bit ei, input bit em, input bit eb);
    chk("addr_we",  bus.addr_we,  ea);
    chk("sr_we",    bus.sr_we,    es);
    chk("dm_we",    bus.dm_we,    ed);
    chk("addr_inc", bus.addr_inc, ei);
    chk("miso_en",  bus.miso_en,  em);
    chk("busy",     bus.busy,     eb);
  endtask

  task automatic step(input bit sck, input bit mo, input bit c);
    bit ea, es, ed, ei, em, eb;
    bus.sck_rise = sck;
    bus.mosi     = mo;
    bus.cs       = c;
    @(posedge clk);
    #1;
    ea = 0; es = 0; ed = 0; ei = 0; em = 0; eb = 0;
    if (c) begin
      m_active = 0; m_edges = 0; m_rd = 0; m_pend = 0;
    end else if (!m_active) begin
      m_active = 1; m_edges = 0; m_rd = 0; m_pend = 0;
      eb = 1;
    end else begin
      es = m_pend;
      m_pend = 0;
      if (sck) begin
        m_edges++;
        ea = (m_edges == ADDR_W);
        if (m_edges == RW_EDGE) begin
          m_rd = mo;
          es = es | mo;
        end
        if (m_edges > RW_EDGE && ((m_edges - RW_EDGE) % DATA_W) == 0 &&
            (BURST || m_edges == RW_EDGE + DATA_W)) begin
          ed = !m_rd;
          if (BURST) begin
            ei = 1;
            m_pend = m_rd;
          end
        end
      end
      em = m_rd && (m_edges >= RW_EDGE);
      eb = 1;
    end
    check_all(ea, es, ed, ei, em, eb);
  endtask

  task automatic txn(input logic [ADDR_W-1:0] addr, input bit rw,
                     input logic [31:0] data, input int nedges, input bit cs_last);
    bit b;
    step(0, 0, 0);
    for (int e = 1; e <= nedges; e++) begin
      repeat ($urandom_range(3, 1)) step(0, 1'($urandom), 0);
      if (e <= ADDR_W)       b = addr[ADDR_W - e];
      else if (e == RW_EDGE) b = rw;
      else                   b = data[31 - (e - RW_EDGE - 1)];
      step(1, b, cs_last && (e == nedges));
    end
    if (!cs_last) begin
      repeat (2) step(0, 0, 0);
      step(0, 0, 1);
    end
    step(0, 0, 1);
  endtask

  initial begin
    bus.sck_rise = 1'b0;
    bus.mosi     = 1'b0;
    bus.cs       = 1'b0;
    reset        = 1'b1;

    for (int i = 0; i < 2; i++) begin
      bus.sck_rise = 1'b1;
      bus.mosi     = 1'b1;
      @(posedge clk);
      #1;
      check_all(0, 0, 0, 0, 0, 0);
      bus.sck_rise = 1'b0;
    end
    bus.cs = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(0, 0, 1);
    repeat (3) step(1, 1, 1);

    txn(7'h2A, 1'b0, 32'hC300_0000, 16, 1'b0);
    txn(7'h05, 1'b1, 32'h5A00_0000, 16, 1'b0);
    txn(7'h11, 1'b0, 32'hF000_0000, 12, 1'b0);
    txn(7'h33, 1'b0, 32'hA500_0000, 16, 1'b1);
    txn(7'h44, 1'b1, 32'h3C00_0000, 16, 1'b1);
    txn(7'h0F, 1'b0, 32'h1234_5600, RW_EDGE + 24, 1'b0);
    txn(7'h70, 1'b1, 32'h9ABC_0000, RW_EDGE + 16, 1'b0);
    txn(7'h01, 1'b0, 32'h0, 5, 1'b0);

    for (int t = 0; t < 24; t++) begin
      txn(7'($urandom), 1'($urandom), 32'($urandom),
          $urandom_range(RW_EDGE + 32, 1), 1'($urandom_range(3, 0) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
